usb_fifo_wr_arb: RTL and testbench



---
 rtl/usb_fifo_wr_arb.sv | 126 ++++++++++++
 tb/tb_usb_fifo_wr_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fifo_wr_arb.sv
// Round-robin write arbiter: two producer streams share one FIFO write port in bounded bursts.
// Define USB_FIFO_ARB_WORD_CNT_EN to add per-requester accepted-word counters (word_cnt0/1).
module usb_fifo_wr_arb #(
  parameter int MAX_BURST = 64,
  parameter int CNT_W     = 9
) (
  input  logic        fifo_clk,
  input  logic        reset_,
  input  logic        req0,
  input  logic        req1,
  input  logic        valid0,
  input  logic        valid1,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  input  logic        last0,
  input  logic        last1,
  output logic        ready0,
  output logic        ready1,
  output logic [31:0] fifo_din,
  output logic        fifo_write_busy,
  input  logic        fifo_full,
  output logic        fifo_flush,
  input  logic        flush_req,
  output logic        flush_ack,
`ifdef USB_FIFO_ARB_WORD_CNT_EN
  output logic [15:0] word_cnt0,
  output logic [15:0] word_cnt1,
`endif
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, FLUSH} state_t;

  state_t           state;
  logic             rr;
  logic [CNT_W-1:0] burst_cnt;
  logic             burst_done;

  // The word accepted while burst_cnt == MAX_BURST-1 brings the count to MAX_BURST.
  assign burst_done = (burst_cnt == CNT_W'(MAX_BURST - 1));

  assign ready0          = (state == GNT0) & valid0 & ~fifo_full;
  assign ready1          = (state == GNT1) & valid1 & ~fifo_full;
  assign fifo_write_busy = ready0 | ready1;
  assign fifo_din        = (state == GNT0) ? din0 :
                           (state == GNT1) ? din1 : 32'd0;

  always_ff @(posedge fifo_clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      grant      <= 2'b00;
      fifo_flush <= 1'b0;
      flush_ack  <= 1'b0;
      rr         <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (flush_req) begin
            state      <= FLUSH;
            fifo_flush <= 1'b1;
            flush_ack  <= 1'b1;
          end else if (req0 && (!req1 || rr)) begin
            state <= GNT0;
            grant <= 2'b01;
          end else if (req1) begin
            state <= GNT1;
            grant <= 2'b10;
          end
        end
        GNT0: begin
          if (ready0) begin
            if (last0 || burst_done) begin
              state <= IDLE;
              grant <= 2'b00;
              rr    <= 1'b0;
            end else begin
              burst_cnt <= burst_cnt + CNT_W'(1);
            end
          end else if (!req0 && !valid0) begin
            state <= IDLE;
            grant <= 2'b00;
            rr    <= 1'b0;
          end
        end
        GNT1: begin
          if (ready1) begin
            if (last1 || burst_done) begin
              state <= IDLE;
              grant <= 2'b00;
              rr    <= 1'b1;
            end else begin
              burst_cnt <= burst_cnt + CNT_W'(1);
            end
          end else if (!req1 && !valid1) begin
            state <= IDLE;
            grant <= 2'b00;
            rr    <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          fifo_flush <= 1'b0;
          flush_ack  <= 1'b0;
        end
      endcase
    end
  end

`ifdef USB_FIFO_ARB_WORD_CNT_EN
  always_ff @(posedge fifo_clk or negedge reset_) begin
    if (!reset_) begin
      word_cnt0 <= 16'd0;
      word_cnt1 <= 16'd0;
    end else if (state == FLUSH) begin
      word_cnt0 <= 16'd0;
      word_cnt1 <= 16'd0;
    end else begin
      if (ready0) word_cnt0 <= word_cnt0 + 16'd1;
      if (ready1) word_cnt1 <= word_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_fifo_wr_arb.sv
// Directed bench for usb_fifo_wr_arb: a per-cycle vector table plus sequences for
// max-length bursts, backpressure, deferred flush, async reset and optional word counters.
module tb_usb_fifo_wr_arb;

  logic        fifo_clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        req0 = 0, req1 = 0, valid0 = 0, valid1 = 0, last0 = 0, last1 = 0;
  logic [31:0] din0 = 0, din1 = 0;
  logic        fifo_full = 0, flush_req = 0;
  logic        ready0, ready1, fifo_write_busy, fifo_flush, flush_ack;
  logic [31:0] fifo_din;
  logic [1:0]  grant;
`ifdef USB_FIFO_ARB_WORD_CNT_EN
  logic [15:0] word_cnt0, word_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 fifo_clk = ~fifo_clk;

  usb_fifo_wr_arb dut (
    .fifo_clk(fifo_clk), .reset_(reset_),
    .req0(req0), .req1(req1), .valid0(valid0), .valid1(valid1),
    .din0(din0), .din1(din1), .last0(last0), .last1(last1),
    .ready0(ready0), .ready1(ready1), .fifo_din(fifo_din),
    .fifo_write_busy(fifo_write_busy), .fifo_full(fifo_full),
    .fifo_flush(fifo_flush), .flush_req(flush_req), .flush_ack(flush_ack),
`ifdef USB_FIFO_ARB_WORD_CNT_EN
    .word_cnt0(word_cnt0), .word_cnt1(word_cnt1),
`endif
    .grant(grant)
  );

  typedef struct packed {
    logic r0, r1, v0, v1, l0, l1, full, fl;
    logic [31:0] d0, d1;
    logic [1:0]  g;
    logic busy, rd0, rd1, fo, ack;
    logic [31:0] fdin;
  } vec_t;

  function automatic vec_t mk(input logic r0, r1, v0, v1, l0, l1, full, fl,
                              input logic [31:0] d0, d1, input logic [1:0] g,
                              input logic busy, rd0, rd1, fo, ack, input logic [31:0] fdin);
    return '{r0, r1, v0, v1, l0, l1, full, fl, d0, d1, g, busy, rd0, rd1, fo, ack, fdin};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({grant, fifo_write_busy, ready0, ready1, fifo_flush, flush_ack, fifo_din});
  endfunction

  task automatic do_reset();
    reset_ = 1'b0;
    {req0, req1, valid0, valid1, last0, last1, fifo_full, flush_req} = '0;
    din0 = 0; din1 = 0;
    repeat (2) @(negedge fifo_clk);
    #1 chk("reset_outputs", outs(), 64'd0);
    reset_ = 1'b1;
  endtask

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    int w, stalls, last_c, flush_c, g1_c, nflush, nwr;
    logic acked;
    logic [1:0] eg;

    // r0 r1 v0 v1 l0 l1 fu fl  d0  d1 | grant busy rd0 rd1 flush ack fdin
    vecs[0]  = mk(0,0,0,0,0,0,0,0, 32'h0,  32'h0,  2'b00,0,0,0,0,0, 32'h0);
    vecs[1]  = mk(1,0,1,0,0,0,0,0, 32'hA0, 32'h0,  2'b00,0,0,0,0,0, 32'h0);
    vecs[2]  = mk(1,0,1,0,0,0,0,0, 32'hA1, 32'h0,  2'b01,1,1,0,0,0, 32'hA1);
    vecs[3]  = mk(1,0,1,0,0,0,1,0, 32'hA2, 32'h0,  2'b01,0,0,0,0,0, 32'hA2);
    vecs[4]  = mk(1,0,1,0,1,0,0,0, 32'hA2, 32'h0,  2'b01,1,1,0,0,0, 32'hA2);
    vecs[5]  = mk(0,1,0,1,0,0,0,0, 32'h0,  32'hB0, 2'b00,0,0,0,0,0, 32'h0);
    vecs[6]  = mk(1,1,1,1,0,0,0,0, 32'hA9, 32'hB0, 2'b10,1,0,1,0,0, 32'hB0);
    vecs[7]  = mk(1,1,1,0,0,0,0,0, 32'hA9, 32'hB0, 2'b10,0,0,0,0,0, 32'hB0);
    vecs[8]  = mk(0,0,0,0,0,0,0,0, 32'h0,  32'hB0, 2'b10,0,0,0,0,0, 32'hB0);
    vecs[9]  = mk(0,0,0,0,0,0,0,1, 32'h0,  32'h0,  2'b00,0,0,0,0,0, 32'h0);
    vecs[10] = mk(0,0,0,0,0,0,0,1, 32'h0,  32'h0,  2'b00,0,0,0,1,1, 32'h0);
    vecs[11] = mk(1,1,0,0,0,0,0,0, 32'h0,  32'h0,  2'b00,0,0,0,0,0, 32'h0);
    vecs[12] = mk(1,1,1,0,1,0,0,0, 32'hC0, 32'h0,  2'b01,1,1,0,0,0, 32'hC0);
    vecs[13] = mk(1,1,0,0,0,0,0,0, 32'h0,  32'h0,  2'b00,0,0,0,0,0, 32'h0);
    vecs[14] = mk(1,1,1,0,0,0,0,0, 32'hC1, 32'h0,  2'b10,0,0,0,0,0, 32'h0);

    // Vector table: inputs applied each cycle, outputs checked before the next edge
    do_reset();
    for (int i = 0; i < NV; i++) begin
      @(negedge fifo_clk);
      {req0, req1, valid0, valid1, last0, last1, fifo_full, flush_req} =
        {vecs[i].r0, vecs[i].r1, vecs[i].v0, vecs[i].v1, vecs[i].l0, vecs[i].l1, vecs[i].full, vecs[i].fl};
      din0 = vecs[i].d0;
      din1 = vecs[i].d1;
      #1 chk($sformatf("vec%0d", i), outs(),
             64'({vecs[i].g, vecs[i].busy, vecs[i].rd0, vecs[i].rd1, vecs[i].fo, vecs[i].ack, vecs[i].fdin}));
    end

    // Both requesters saturated: 64-word bursts alternating 01,10,01 with one idle bubble
    do_reset();
    nwr = 0;
    for (int c = 0; c < 196; c++) begin
      @(negedge fifo_clk);
      req0 = 1; req1 = 1; valid0 = 1; valid1 = 1;
      din0 = 32'h0000_A5A5; din1 = 32'h5A5A_0000;
      if (c == 0 || (c - 1) % 65 == 64) eg = 2'b00;
      else eg = (((c - 1) / 65) % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      if (fifo_write_busy) nwr++;
      if (grant !== eg || fifo_write_busy !== (eg != 2'b00) ||
          fifo_din !== (eg == 2'b01 ? din0 : eg == 2'b10 ? din1 : 32'd0))
        chk($sformatf("rr_cycle%0d", c), 64'({grant, fifo_write_busy, fifo_din}),
            64'({eg, eg != 2'b00, (eg == 2'b01 ? din0 : eg == 2'b10 ? din1 : 32'd0)}));
    end
    chk("rr_total_writes", 64'(nwr), 64'd192);

    // Backpressure: 10-word packet, fifo_full for 5 cycles mid-burst
    do_reset();
    w = 0; stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge fifo_clk);
      fifo_full = (c >= 4 && c < 9);
      req0 = (w < 10); valid0 = (w < 10);
      din0 = 32'hB000_0000 | 32'(w); last0 = (w == 9);
      #1;
      if (c == 1) chk("bp_grant_latency", 64'(grant), 64'h1);
      if (grant == 2'b01 && fifo_full) begin
        stalls++;
        if (fifo_write_busy || ready0) chk("bp_stall_strobe", 64'({fifo_write_busy, ready0}), 64'd0);
      end else if (fifo_write_busy) begin
        if (fifo_din !== (32'hB000_0000 | 32'(w)))
          chk("bp_data", 64'(fifo_din), 64'(32'hB000_0000 | 32'(w)));
        w++;
      end
    end
    fifo_full = 0;
    chk("bp_words", 64'(w), 64'd10);
    chk("bp_stall_cycles", 64'(stalls), 64'd5);
    chk("bp_end_grant", 64'(grant), 64'd0);

    // Flush requested mid-burst waits for the burst end, then requester 1 is served
    do_reset();
    w = 0; last_c = -1; flush_c = -1; g1_c = -1; nflush = 0; acked = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge fifo_clk);
      req0 = (w < 20); valid0 = (w < 20); din0 = 32'(w); last0 = (w == 19);
      req1 = 1; valid1 = 0;
      flush_req = (w >= 3) && !acked;
      #1;
      if (fifo_write_busy && grant == 2'b01) begin
        if (w == 19) last_c = c;
        w++;
      end
      if (fifo_flush) begin
        nflush++; flush_c = c; acked = 1;
        chk("fl_ack_coincides", 64'(flush_ack), 64'd1);
      end
      if (grant == 2'b10 && g1_c < 0) g1_c = c;
    end
    req1 = 0; flush_req = 0;
    chk("fl_words", 64'(w), 64'd20);
    chk("fl_pulse_count", 64'(nflush), 64'd1);
    chk("fl_pulse_cycle", 64'(flush_c), 64'(last_c + 2));
    chk("fl_req1_served", 64'(g1_c), 64'(flush_c + 2));

    // Asynchronous reset at word 7, then requester 0 wins first
    do_reset();
    w = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge fifo_clk);
      req0 = 1; valid0 = 1; din0 = 32'hD000_0000 | 32'(w);
      #1;
      if (fifo_write_busy) w++;
      if (w == 7) begin
        #1 reset_ = 1'b0;
        #1 chk("async_reset_outputs", outs(), 64'd0);
        break;
      end
    end
    chk("async_reset_word", 64'(w), 64'd7);
    @(negedge fifo_clk);
    reset_ = 1'b1; req0 = 1; req1 = 1; valid0 = 0;
    #1 chk("post_reset_idle", 64'(grant), 64'd0);
    @(negedge fifo_clk);
    #1 chk("post_reset_grant", 64'(grant), 64'h1);

`ifdef USB_FIFO_ARB_WORD_CNT_EN
    // 300 words from requester 1, then a flush clears the totals
    do_reset();
    w = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge fifo_clk);
      req1 = (w < 300); valid1 = (w < 300); din1 = 32'(w);
      #1;
      if (fifo_write_busy) w++;
    end
    req1 = 0; valid1 = 0;
    @(negedge fifo_clk);
    chk("wc_cnt1", 64'(word_cnt1), 64'd300);
    chk("wc_cnt0", 64'(word_cnt0), 64'd0);
    flush_req = 1;
    @(negedge fifo_clk);
    @(negedge fifo_clk);
    flush_req = 0;
    @(negedge fifo_clk);
    chk("wc_cnt1_flushed", 64'(word_cnt1), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
